// File: rtl/uart_reg_pkg.sv
// Shared constants and FSM encodings for the UART register command controller.
package uart_reg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_EXEC,
    ST_RD_WAIT,
    ST_SEND_ACK,
    ST_SEND_DATA
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_KICK,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte UART TX handshake: kick, wait for the UART to go busy, wait for it to finish.
// done pulses on completion; a send in that same cycle chains straight into the next kick.
module uart_byte_sender
  import uart_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] send_byte,
  input  logic       is_transmitting,
  output logic       tx_enable,
  output logic [7:0] tx_byte,
  output logic       done
);

  tx_state_t  state_q, state_d;
  logic [7:0] byte_q;
  logic       accept;

  assign tx_byte = byte_q;

  always_comb begin
    state_d   = state_q;
    tx_enable = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      TX_IDLE: accept = send;
      TX_KICK: begin
        if (!is_transmitting) begin
          tx_enable = 1'b1;
          state_d   = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: begin
        if (is_transmitting) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!is_transmitting) begin
          done    = 1'b1;
          state_d = TX_IDLE;
          accept  = send;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (accept) state_d = TX_KICK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) byte_q <= send_byte;
    end
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// Host command controller: parses SYNC/CMD/ADDR/DATA frames from the UART, runs one
// local-bus register access and replies ACK (+ read data) or NAK over the UART TX.
module uart_reg_ctrl
  import uart_reg_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd1000000,
  parameter int          ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_available,
  input  logic             is_transmitting,
  output logic             tx_enable,
  output logic [7:0]       tx_byte,
  output logic             reg_wr,
  output logic             reg_rd,
  output logic [7:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  input  logic [7:0]       reg_rdata,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  ctrl_state_t state_q, state_d;
  logic [7:0]  cmd_q;
  logic [7:0]  rdata_q;
  logic [23:0] tmo_cnt;
  logic        in_get;
  logic        timed_out;
  logic        err_inc;
  logic        send;
  logic [7:0]  send_byte;
  logic        tx_done;

  assign in_get    = state_q inside {ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA};
  // An arriving byte always beats an expiring timeout.
  assign timed_out = in_get && !rx_available && (tmo_cnt >= TIMEOUT);
  assign busy      = (state_q != ST_IDLE);
  assign reg_wr    = (state_q == ST_EXEC) && (cmd_q == CMD_WR);
  assign reg_rd    = (state_q == ST_EXEC) && (cmd_q == CMD_RD);

  always_comb begin
    state_d   = state_q;
    send      = 1'b0;
    send_byte = ACK_BYTE;
    err_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_available && rx_byte == SYNC_BYTE) state_d = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (rx_available) state_d = ST_GET_ADDR;
      end
      ST_GET_ADDR: begin
        if (rx_available) state_d = ST_GET_DATA;
      end
      ST_GET_DATA: begin
        if (rx_available) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cmd_q == CMD_RD) begin
          state_d = ST_RD_WAIT;
        end else begin
          send    = 1'b1;
          state_d = ST_SEND_ACK;
          if (cmd_q != CMD_WR) begin
            send_byte = NAK_BYTE;
            err_inc   = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        send    = 1'b1;
        state_d = ST_SEND_ACK;
      end
      ST_SEND_ACK: begin
        if (tx_done) begin
          if (cmd_q == CMD_RD) begin
            send      = 1'b1;
            send_byte = rdata_q;
            state_d   = ST_SEND_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND_DATA: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (timed_out) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      rdata_q   <= 8'h00;
      tmo_cnt   <= 24'd0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if (rx_available) begin
        case (state_q)
          ST_GET_CMD:  cmd_q     <= rx_byte;
          ST_GET_ADDR: reg_addr  <= rx_byte;
          ST_GET_DATA: reg_wdata <= rx_byte;
          default:     ;
        endcase
      end
      if (state_q == ST_RD_WAIT) rdata_q <= reg_rdata;
      if (!in_get || rx_available) tmo_cnt <= 24'd0;
      else if (tmo_cnt != '1)      tmo_cnt <= tmo_cnt + 24'd1;
      if (err_inc && err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end

  uart_byte_sender u_sender (
    .clk             (clk),
    .rst             (rst),
    .send            (send),
    .send_byte       (send_byte),
    .is_transmitting (is_transmitting),
    .tx_enable       (tx_enable),
    .tx_byte         (tx_byte),
    .done            (tx_done)
  );

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl with a UART TX model and a register-file model.
module tb_uart_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_available;
  logic       is_transmitting = 1'b0;
  logic       tx_enable;
  logic [7:0] tx_byte;
  logic       reg_wr, reg_rd;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'hC3;
  logic       busy;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_reg_ctrl #(.TIMEOUT(24'd40), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_available(rx_available),
    .is_transmitting(is_transmitting), .tx_enable(tx_enable), .tx_byte(tx_byte),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
  );

  int total = 0, bad = 0;
  int cyc = 0, rx_cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0, tx_overlap = 0, tx_timer = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  logic [7:0] tx_log[$];
  int         tx_cyc_log[$];
  logic [7:0] mem[256];
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  int exp_err, base_wr, base_rd, base_tx;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_available) rx_cyc <= cyc;
  end

  // UART TX model (busy 2 cycles after kick, for 4 cycles) and register file whose
  // read data is valid only in the cycle after reg_rd.
  always @(negedge clk) begin
    reg_rdata = rd_pend ? mem[rd_addr] : 8'hC3;
    rd_pend   = reg_rd;
    rd_addr   = reg_addr;
    if (reg_wr) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = reg_addr; wr_data = reg_wdata;
      mem[reg_addr] = reg_wdata;
    end
    if (reg_rd) begin
      rd_cnt++; rd_cyc = cyc;
    end
    if (tx_enable) begin
      if (tx_timer != 0) tx_overlap++;
      tx_log.push_back(tx_byte);
      tx_cyc_log.push_back(cyc);
      tx_timer = 6;
    end else if (tx_timer > 0) begin
      tx_timer--;
    end
    is_transmitting = (tx_timer > 0 && tx_timer <= 4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    @(negedge clk); #1;
    rx_byte = b; rx_available = 1'b1;
    @(negedge clk); #1;
    rx_available = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic put_frame(input int n, input logic [47:0] bytes, input int gap);
    for (int i = 0; i < n; i++) put_byte(bytes[47 - 8*i -: 8], gap);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((busy !== 1'b0 || is_transmitting) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, n < 300, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    base_wr = wr_cnt; base_rd = rd_cnt; base_tx = tx_log.size();
  endtask

  typedef struct {
    int          n;
    logic [47:0] bytes;
    int          wr;
    int          rd;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          ntx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    int          err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h77;

    vecs[0] = '{4, 48'hA5_01_10_3C_00_00, 1, 0, 8'h10, 8'h3C, 1, 8'h5A, 8'h00, 0};
    vecs[1] = '{4, 48'hA5_02_20_99_00_00, 0, 1, 8'h20, 8'h00, 2, 8'h5A, 8'h77, 0};
    vecs[2] = '{6, 48'h00_FF_A5_01_11_22, 1, 0, 8'h11, 8'h22, 1, 8'h5A, 8'h00, 0};
    vecs[3] = '{4, 48'hA5_02_11_00_00_00, 0, 1, 8'h11, 8'h00, 2, 8'h5A, 8'h22, 0};
    vecs[4] = '{4, 48'hA5_7E_00_00_00_00, 0, 0, 8'h00, 8'h00, 1, 8'hEE, 8'h00, 1};
    vecs[5] = '{4, 48'hA5_A5_30_40_00_00, 0, 0, 8'h00, 8'h00, 1, 8'hEE, 8'h00, 1};

    rst = 1'b1; rx_available = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_byte",   tx_byte,   0);
    chk("rst_reg_wr",    reg_wr,    0);
    chk("rst_reg_rd",    reg_rd,    0);
    chk("rst_reg_addr",  reg_addr,  0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    exp_err = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      snap();
      put_frame(v.n, v.bytes, 0);
      wait_idle($sformatf("v%0d", i));
      exp_err += v.err;
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt - base_wr, v.wr);
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt - base_rd, v.rd);
      if (v.wr != 0) begin
        chk($sformatf("v%0d_wr_lat", i),   wr_cyc - rx_cyc, 1);
        chk($sformatf("v%0d_wr_addr", i),  wr_addr, v.addr);
        chk($sformatf("v%0d_wr_wdata", i), wr_data, v.wdata);
      end
      if (v.rd != 0) begin
        chk($sformatf("v%0d_rd_lat", i), rd_cyc - rx_cyc, 1);
        chk($sformatf("v%0d_addr", i),   reg_addr, v.addr);
      end
      chk($sformatf("v%0d_ntx", i), tx_log.size() - base_tx, v.ntx);
      if (tx_log.size() > base_tx) begin
        chk($sformatf("v%0d_tx0", i), tx_log[base_tx], v.tx0);
        chk($sformatf("v%0d_tx_lat", i), tx_cyc_log[base_tx] - rx_cyc, (v.rd != 0) ? 3 : 2);
      end
      if (v.ntx > 1 && tx_log.size() > base_tx + 1)
        chk($sformatf("v%0d_tx1", i), tx_log[base_tx + 1], v.tx1);
      chk($sformatf("v%0d_err", i),  err_count, exp_err);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end
    chk("hold_wdata", reg_wdata, 8'h40);

    // Timeout: SYNC + CMD then silence well beyond TIMEOUT.
    snap();
    put_byte(8'hA5, 0);
    put_byte(8'h01, 0);
    chk("tmo_busy_mid", busy, 1);
    repeat (60) @(negedge clk);
    #1;
    exp_err++;
    chk("tmo_busy", busy, 0);
    chk("tmo_ntx",  tx_log.size() - base_tx, 0);
    chk("tmo_wr",   wr_cnt - base_wr, 0);
    chk("tmo_err",  err_count, exp_err);

    // Long but legal gaps between frame bytes.
    snap();
    put_frame(4, 48'hA5_01_40_5C_00_00, 30);
    wait_idle("gap");
    chk("gap_wr",   wr_cnt - base_wr, 1);
    chk("gap_addr", wr_addr, 8'h40);
    chk("gap_err",  err_count, exp_err);

    // A SYNC arriving while the reply is in flight must be ignored.
    snap();
    put_frame(4, 48'hA5_01_50_66_00_00, 0);
    put_byte(8'hA5, 0);
    wait_idle("drop");
    repeat (50) @(negedge clk);
    #1;
    chk("drop_busy", busy, 0);
    chk("drop_err",  err_count, exp_err);
    chk("drop_ntx",  tx_log.size() - base_tx, 1);

    // Reset while the read data byte is being transmitted.
    snap();
    put_frame(4, 48'hA5_02_20_00_00_00, 0);
    n = 0;
    while (tx_log.size() < base_tx + 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rstmid_reached", n < 200, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    exp_err = 0;
    chk("rstmid_tx_enable", tx_enable, 0);
    chk("rstmid_busy",      busy,      0);
    chk("rstmid_reg_addr",  reg_addr,  0);
    chk("rstmid_err",       err_count, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("rstmid_no_more_tx", tx_log.size() - base_tx, 2);
    snap();
    put_frame(4, 48'hA5_01_12_34_00_00, 0);
    wait_idle("after_rst");
    chk("after_rst_wr",    wr_cnt - base_wr, 1);
    chk("after_rst_wdata", wr_data, 8'h34);
    chk("after_rst_ntx",   tx_log.size() - base_tx, 1);
    if (tx_log.size() > base_tx) chk("after_rst_tx0", tx_log[base_tx], 8'h5A);

    // Error counter saturation.
    for (int i = 0; i < 255; i++) begin
      put_frame(4, 48'hA5_33_00_00_00_00, 0);
      wait_idle("sat_fill");
    end
    chk("sat_255", err_count, 8'hFF);
    snap();
    put_frame(4, 48'hA5_33_00_00_00_00, 0);
    wait_idle("sat_hold");
    chk("sat_hold", err_count, 8'hFF);
    if (tx_log.size() > base_tx) chk("sat_nak", tx_log[base_tx], 8'hEE);
    chk("tx_overlap", tx_overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
